// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle for the S00_AXI register-file port.
// The master modport is the bus driver; the slave modport is the register file.
interface axi4lite_reg_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                      awprot;
  logic                            awvalid;
  logic                            awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                            wvalid;
  logic                            wready;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                      arprot;
  logic                            arvalid;
  logic                            arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                      rresp;
  logic                            rvalid;
  logic                            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave register file: NUM_REGS read/write registers with byte strobes,
// independent AW/W acceptance, and per-register commit pulses for user logic.
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                               s00_axi_aclk,
  input  logic                               s00_axi_aresetn,
  axi4lite_reg_slave_if.slave                s00_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                reg_wr_pulse
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_VALID
  } rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic                          awready_q;
  logic                          wready_q;
  logic                          arready_q;
  logic [IDX_W-1:0]              aw_idx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]             wstrb_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                          aw_hs;
  logic                          w_hs;
  logic                          ar_hs;
  logic [IDX_W-1:0]              aw_idx_in;
  logic [IDX_W-1:0]              ar_idx_in;
  logic                          commit;
  logic [IDX_W-1:0]              commit_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] commit_data;
  logic [STRB_W-1:0]             commit_strb;

  assign aw_hs     = s00_axi.awvalid && awready_q;
  assign w_hs      = s00_axi.wvalid && wready_q;
  assign ar_hs     = s00_axi.arvalid && arready_q;
  assign aw_idx_in = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx_in = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  // Protection bits and byte-lane address bits carry no meaning for word registers.
  logic unused_ok;
  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot,
                       s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  // Write channel: commit happens on whichever edge completes the second of AW/W,
  // taking the live bus value for the half that completes on that edge.
  always_comb begin
    wr_state_nxt = wr_state;
    commit       = 1'b0;
    commit_idx   = aw_idx_q;
    commit_data  = wdata_q;
    commit_strb  = wstrb_q;
    unique case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit       = 1'b1;
          commit_idx   = aw_idx_in;
          commit_data  = s00_axi.wdata;
          commit_strb  = s00_axi.wstrb;
          wr_state_nxt = WR_RESP;
        end else if (aw_hs) begin
          wr_state_nxt = WR_HAVE_AW;
        end else if (w_hs) begin
          wr_state_nxt = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        if (w_hs) begin
          commit       = 1'b1;
          commit_data  = s00_axi.wdata;
          commit_strb  = s00_axi.wstrb;
          wr_state_nxt = WR_RESP;
        end
      end
      WR_HAVE_W: begin
        if (aw_hs) begin
          commit       = 1'b1;
          commit_idx   = aw_idx_in;
          wr_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s00_axi.bready) begin
          wr_state_nxt = WR_IDLE;
        end
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    unique case (rd_state)
      RD_IDLE:  if (ar_hs) rd_state_nxt = RD_VALID;
      RD_VALID: if (s00_axi.rready) rd_state_nxt = RD_IDLE;
      default:  rd_state_nxt = RD_IDLE;
    endcase
  end

  // Readies are registered from the next state, so they stay low in reset
  // and rise on the first edge after release.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_state  <= WR_IDLE;
      rd_state  <= RD_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      wr_state  <= wr_state_nxt;
      rd_state  <= rd_state_nxt;
      awready_q <= (wr_state_nxt == WR_IDLE) || (wr_state_nxt == WR_HAVE_W);
      wready_q  <= (wr_state_nxt == WR_IDLE) || (wr_state_nxt == WR_HAVE_AW);
      arready_q <= (rd_state_nxt == RD_IDLE);
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= aw_idx_in;
      if (w_hs) begin
        wdata_q <= s00_axi.wdata;
        wstrb_q <= s00_axi.wstrb;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      regs         <= '{default: '0};
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        reg_wr_pulse <= NUM_REGS'(1) << commit_idx;
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (commit_strb[b]) regs[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
        end
      end
    end
  end

  // Read data samples the register array before any same-edge commit lands.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rdata_q <= '0;
    end else if (ar_hs) begin
      rdata_q <= regs[ar_idx_in];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = regs[g];
  end

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = wready_q;
  assign s00_axi.bvalid  = (wr_state == WR_RESP);
  assign s00_axi.bresp   = '0;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = (rd_state == RD_VALID);
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = '0;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Bench for axi4lite_reg_slave: directed AXI4-Lite traffic, a transaction-level
// register model checked against the DUT every cycle, plus literal expectations.
module tb_axi4lite_reg_slave;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axi4lite_reg_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;

  axi4lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .NUM_REGS(4)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi        (bus),
    .reg_out        (reg_out),
    .reg_wr_pulse   (reg_wr_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt [4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending AW/W halves, register contents,
  // outstanding write response and queue of read data owed to the master.
  logic [31:0] m_regs [4] = '{default: '0};
  logic        m_aw_pend = 1'b0;
  logic        m_w_pend  = 1'b0;
  logic        m_b_pend  = 1'b0;
  logic        m_live    = 1'b0;
  logic [1:0]  m_aw_idx  = '0;
  logic [31:0] m_wd      = '0;
  logic [3:0]  m_ws      = '0;
  logic [3:0]  m_pulse   = '0;
  logic [31:0] rq [$];

  logic aw_hs, w_hs, ar_hs, r_hs, b_hs, have_aw, have_w;
  logic [1:0]  c_idx;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  assign aw_hs   = bus.awvalid && bus.awready;
  assign w_hs    = bus.wvalid && bus.wready;
  assign ar_hs   = bus.arvalid && bus.arready;
  assign r_hs    = bus.rvalid && bus.rready;
  assign b_hs    = bus.bvalid && bus.bready;
  assign have_aw = m_aw_pend || aw_hs;
  assign have_w  = m_w_pend || w_hs;
  assign c_idx   = aw_hs ? bus.awaddr[3:2] : m_aw_idx;
  assign c_data  = w_hs ? bus.wdata : m_wd;
  assign c_strb  = w_hs ? bus.wstrb : m_ws;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_regs    <= '{default: '0};
      m_aw_pend <= 1'b0;
      m_w_pend  <= 1'b0;
      m_b_pend  <= 1'b0;
      m_live    <= 1'b0;
      m_pulse   <= '0;
      rq.delete();
    end else begin
      m_live  <= 1'b1;
      m_pulse <= '0;
      if (r_hs && rq.size() > 0) void'(rq.pop_front());
      if (ar_hs) rq.push_back(m_regs[bus.araddr[3:2]]);
      if (b_hs) m_b_pend <= 1'b0;
      if (aw_hs) begin
        m_aw_pend <= 1'b1;
        m_aw_idx  <= bus.awaddr[3:2];
      end
      if (w_hs) begin
        m_w_pend <= 1'b1;
        m_wd     <= bus.wdata;
        m_ws     <= bus.wstrb;
      end
      if (have_aw && have_w) begin
        m_regs[c_idx] <= merge(m_regs[c_idx], c_data, c_strb);
        m_pulse       <= 4'b0001 << c_idx;
        m_b_pend      <= 1'b1;
        m_aw_pend     <= 1'b0;
        m_w_pend      <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("reg_out", reg_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    chk("reg_wr_pulse", 128'(reg_wr_pulse), 128'(m_pulse));
    chk("bvalid", 128'(bus.bvalid), 128'(m_b_pend));
    chk("rvalid", 128'(bus.rvalid), 128'(rq.size() != 0));
    chk("awready", 128'(bus.awready), 128'(m_live && !m_aw_pend && !m_b_pend));
    chk("wready", 128'(bus.wready), 128'(m_live && !m_w_pend && !m_b_pend));
    chk("arready", 128'(bus.arready), 128'(m_live && rq.size() == 0));
    if (bus.bvalid) chk("bresp", 128'(bus.bresp), 128'd0);
    if (bus.rvalid) chk("rresp", 128'(bus.rresp), 128'd0);
    if (bus.rvalid && rq.size() != 0) chk("rdata", 128'(bus.rdata), 128'(rq[0]));
    for (int k = 0; k < 4; k++) pulse_cnt[k] += int'(reg_wr_pulse[k]);
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int unsigned aw_dly,
                           input int unsigned w_dly);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_now, w_now;
    int unsigned cyc = 0;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 60) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      aw_done = aw_done || aw_now;
      w_done  = w_done || w_now;
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done)) chk("wr_handshake_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_b(output int unsigned lat);
    bit seen = 1'b0;
    lat = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      seen = bus.bvalid && bus.bready;
      @(posedge clk); #1;
    end
    if (!seen) chk("b_timeout", 128'd0, 128'd1);
  endtask

  task automatic ar_issue(input logic [3:0] addr);
    bit done = 1'b0;
    int unsigned cyc = 0;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      done = bus.arready;
      @(posedge clk); #1;
      cyc++;
    end
    bus.arvalid = 1'b0;
    if (!done) chk("ar_timeout", 128'd0, 128'd1);
  endtask

  task automatic r_collect(output logic [31:0] data, output int unsigned lat);
    bit seen = 1'b0;
    lat  = 0;
    data = '0;
    bus.rready = 1'b1;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      seen = bus.rvalid;
      if (seen) data = bus.rdata;
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    if (!seen) chk("r_timeout", 128'd0, 128'd1);
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    int unsigned lat;
    ar_issue(addr);
    r_collect(data, lat);
    chk("r_latency", 128'(lat), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  d, d2;
    int unsigned  lat;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset, then readies rise one edge after release
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_awready", 128'(bus.awready), 128'd0);
    chk("reset_arready", 128'(bus.arready), 128'd0);
    rst_n = 1'b1;
    #1 chk("release_awready_pre_edge", 128'(bus.awready), 128'd0);
    @(negedge clk);
    chk("release_awready", 128'(bus.awready), 128'd1);
    chk("release_wready", 128'(bus.wready), 128'd1);
    chk("release_arready", 128'(bus.arready), 128'd1);
    @(posedge clk); #1;

    // Sequential full-word writes then readback
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
      wait_b(lat);
      chk("b_latency", 128'(lat), 128'd1);
    end
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d);
      chk("seq_readback", 128'(d), 128'(i + 1));
    end
    chk("seq_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);
    for (int k = 0; k < 4; k++) chk("seq_pulse_count", 128'(pulse_cnt[k]), 128'd1);

    // Byte strobes
    axi_write(4'h4, 32'hAABBCCDD, 4'hF, 0, 0);
    wait_b(lat);
    axi_write(4'h4, 32'h11223344, 4'h5, 0, 0);
    wait_b(lat);
    rd(4'h4, d);
    chk("strobe_merge", 128'(d), 128'hAA22CC44);

    // W three cycles ahead of AW
    axi_write(4'h8, 32'hCAFE0008, 4'hF, 3, 0);
    wait_b(lat);
    chk("w_first_b_latency", 128'(lat), 128'd1);
    chk("w_first_reg2", 128'(reg_out[95:64]), 128'hCAFE0008);

    // Back-pressured write response blocks further AW/W
    bus.bready = 1'b0;
    axi_write(4'hC, 32'h12345678, 4'hF, 0, 0);
    bus.awaddr  = 4'h0;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_bvalid", 128'(bus.bvalid), 128'd1);
      chk("hold_awready", 128'(bus.awready), 128'd0);
      chk("hold_wready", 128'(bus.wready), 128'd0);
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    bus.bready  = 1'b1;
    @(negedge clk);
    chk("bready_edge_awready", 128'(bus.awready), 128'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_b_awready", 128'(bus.awready), 128'd1);
    chk("after_b_bvalid", 128'(bus.bvalid), 128'd0);
    @(posedge clk); #1;
    axi_write(4'h0, 32'h00000077, 4'hF, 0, 0);
    wait_b(lat);

    // Commit and AR to the same register on the same edge
    axi_write(4'h0, 32'h00000005, 4'hF, 0, 0);
    wait_b(lat);
    fork
      axi_write(4'h0, 32'h00000009, 4'hF, 0, 0);
      ar_issue(4'h0);
    join
    wait_b(lat);
    r_collect(d, lat);
    chk("same_edge_read_old", 128'(d), 128'h5);
    rd(4'h0, d2);
    chk("same_edge_read_new", 128'(d2), 128'h9);

    // Asynchronous reset with both responses outstanding
    bus.bready = 1'b0;
    axi_write(4'h4, 32'hDEAD0004, 4'hF, 0, 0);
    ar_issue(4'h8);
    @(negedge clk);
    chk("pre_reset_bvalid", 128'(bus.bvalid), 128'd1);
    chk("pre_reset_rvalid", 128'(bus.rvalid), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_bvalid", 128'(bus.bvalid), 128'd0);
    chk("async_rvalid", 128'(bus.rvalid), 128'd0);
    bus.bready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rerelease_arready_pre_edge", 128'(bus.arready), 128'd0);
    @(negedge clk);
    chk("rerelease_awready", 128'(bus.awready), 128'd1);
    chk("rerelease_arready", 128'(bus.arready), 128'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d);
      chk("post_reset_read", 128'(d), 128'd0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4lite_reg_slave.md
Name: axi4lite_reg_slave

Overview:
- AXI4-Lite slave register file: the responder end of the S00_AXI bus driven by the VIP master in the IP_psds bench.
- Holds NUM_REGS 32-bit read/write registers.
- Accepts AW and W channels independently, in either order.
- Exposes register contents and per-register write strobes to the IP's user logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; word index = addr[C_S_AXI_ADDR_WIDTH-1:2].
NUM_REGS, 4, register count; must equal 2**(C_S_AXI_ADDR_WIDTH-2).

Ports:
s00_axi_aclk  in  1  clock; all logic on its rising edge.
s00_axi_aresetn  in  1  reset; asynchronous, active-low.
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
s00_axi_awprot  in  3  ignored.
s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake.
s00_axi_wdata  in  32  write data.
s00_axi_wstrb  in  4  byte enables.
s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake.
s00_axi_bresp  out  2  always 2'b00 (OKAY).
s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake.
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
s00_axi_arprot  in  3  ignored.
s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake.
s00_axi_rdata  out  32  read data.
s00_axi_rresp  out  2  always 2'b00.
s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake.
reg_out  out  NUM_REGS*32  register contents; reg k at bits [32k+31:32k].
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on reg k commit.

Behaviour:
- Reset (async assert, sync release): all registers, rdata, resp, valids, readies, pulses = 0. Pending AW/W/AR/B/R are discarded. Readies are registered: they go high at the first edge after release.
- Write side state: aw_held, w_held, bvalid.
  - awready = !aw_held && !bvalid.
  - wready = !w_held && !bvalid.
  - AW handshake latches the word index and sets aw_held.
  - W handshake latches data and strobe and sets w_held.
  - Commit edge = the edge where the second of AW/W completes. AW and W may complete on the same edge; then that edge commits directly.
  - On the commit edge: register[idx] byte b <= wdata byte b where wstrb[b]=1; other bytes unchanged. Also bvalid <= 1, reg_wr_pulse[idx] <= 1 for exactly one cycle, aw_held/w_held cleared.
  - wstrb = 0 still commits (no data change), pulses, and responds.
  - bvalid holds until bready is sampled high, then clears; readies return the next cycle.
  - Max write throughput: one per 2 cycles when bready is held high.
- Read side state: rvalid.
  - arready = !rvalid.
  - AR handshake edge: rdata <= register[araddr index] as it was before that edge; rvalid <= 1.
  - rdata/rvalid hold stable until rready is sampled high. rdata retains its last value afterwards.
- Address: bits [1:0] ignored; no decode errors.
- Simultaneous events:
  - Write commit and AR to the same register on the same edge -> read returns the pre-write value.
  - Reads and writes are fully independent; neither blocks the other.
- reg_out reflects the committed value from the edge after commit.
- Latency: BVALID 1 cycle after final AW/W handshake; RVALID 1 cycle after AR handshake.

Test Plan:
- Sequential AXI4-Lite writes of 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC with wstrb=0xF, then reads from the same addresses -> rdata 0x1..0x4, all resp OKAY; reg_out = {4,3,2,1}; each reg_wr_pulse bit fires once.
- Write 0xAABBCCDD to 0x4, then 0x11223344 with wstrb=0x5 -> read 0x4 returns 0xAA22CC44.
- W presented 3 cycles before AW to 0x8 -> wready handshake alone gives no bvalid; bvalid rises 1 cycle after AW handshake; reg 2 is updated.
- bready held low 10 cycles after a write -> bvalid stays 1 with awready=wready=0 throughout; a second AW is not accepted until 1 cycle after bready.
- Reg0=0x5 committed, then a new 0x9 commit on the same edge as an AR to 0x0 -> first read returns 0x5; a subsequent read returns 0x9.
- Assert aresetn low while bvalid=1 and rvalid=1 -> both drop immediately; registers read 0x0 after release; readies high one edge after release.
